// File: rtl/stage_2_control.sv
// Purpose: stage 2 fetch controller; reads the 4-word instruction at in_pc and then its A/B operands, strobing the stage 2 register write enables.
// Latency: out_valid 8 cycles after the accepting IDLE cycle, 7 when operand A is forwarded.
// Backpressure: holds out_valid in DONE until out_ready, with no memory reads; in_ready only in IDLE.
//
// Ports:
//   CLK, reset        rising-edge clock, synchronous active-high reset
//   flush             synchronous abort back to IDLE
//   in_valid/in_ready/in_pc       instruction pointer handshake from stage 1
//   mem_rd/mem_addr/MemOut        memory read port, data returns the cycle after mem_rd
//   fwd_valid/fwd_addr            pending result of a later stage (operand A bypass)
//   writeOp/writeA/writeB/writeDest/valA   stage 2 register write enables and A-source select
//   out_valid/out_ready           completed instruction handshake to downstream
//
// Build option: define STAGE2_FWD_EN to enable the operand A forward path.
module stage_2_control (
  input  logic        CLK,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] in_pc,
  output logic        in_ready,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  input  logic [15:0] MemOut,
  input  logic        fwd_valid,
  input  logic [15:0] fwd_addr,
  output logic        writeOp,
  output logic        writeA,
  output logic        writeB,
  output logic        writeDest,
  output logic        valA,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [3:0] {
    IDLE, RD0, RD1, RD2, RD3, RDA, RDB, WB, DONE
  } state_t;

  state_t      state;
  state_t      nextState;
  logic [15:0] pcR;
  logic [15:0] aaddrR;
  logic [15:0] baddrR;
  logic        fwdHit;

  logic        inReadyC;
  logic        memRdC;
  logic [15:0] memAddrC;
  logic        writeOpC;
  logic        writeAC;
  logic        writeBC;
  logic        writeDestC;
  logic        valAC;
  logic        outValidC;

`ifdef STAGE2_FWD_EN
  assign fwdHit = fwd_valid && (fwd_addr == aaddrR);
`else
  // Forward inputs are deliberately unused in this build.
  logic unusedFwd;
  assign unusedFwd = ^{fwd_valid, fwd_addr};
  assign fwdHit    = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (reset) begin
      state  <= IDLE;
      pcR    <= 16'h0000;
      aaddrR <= 16'h0000;
      baddrR <= 16'h0000;
    end else begin
      state <= nextState;
      if (state == IDLE && in_valid && !flush) pcR <= in_pc;
      if (state == RD2 && !flush) aaddrR <= MemOut;
      if (state == RD3 && !flush) baddrR <= MemOut;
    end
  end

  always_comb begin
    nextState  = state;
    inReadyC   = 1'b0;
    memRdC     = 1'b0;
    memAddrC   = 16'h0000;
    writeOpC   = 1'b0;
    writeAC    = 1'b0;
    writeBC    = 1'b0;
    writeDestC = 1'b0;
    valAC      = 1'b0;
    outValidC  = 1'b0;
    case (state)
      IDLE: begin
        inReadyC = 1'b1;
        if (in_valid) nextState = RD0;
      end
      RD0: begin
        memRdC    = 1'b1;
        memAddrC  = pcR;
        nextState = RD1;
      end
      RD1: begin
        writeOpC  = 1'b1;
        memRdC    = 1'b1;
        memAddrC  = pcR + 16'd1;
        nextState = RD2;
      end
      RD2: begin
        memRdC    = 1'b1;
        memAddrC  = pcR + 16'd2;
        nextState = RD3;
      end
      RD3: begin
        memRdC    = 1'b1;
        memAddrC  = pcR + 16'd3;
        nextState = RDA;
      end
      RDA: begin
        // MemOut carries the Dest word here; a forward hit takes A from
        // valA1 in the same cycle and skips the A memory read.
        writeDestC = 1'b1;
        memRdC     = 1'b1;
        if (fwdHit) begin
          writeAC   = 1'b1;
          valAC     = 1'b1;
          memAddrC  = baddrR;
          nextState = WB;
        end else begin
          memAddrC  = aaddrR;
          nextState = RDB;
        end
      end
      RDB: begin
        writeAC   = 1'b1;
        memRdC    = 1'b1;
        memAddrC  = baddrR;
        nextState = WB;
      end
      WB: begin
        writeBC   = 1'b1;
        nextState = DONE;
      end
      DONE: begin
        outValidC = 1'b1;
        if (out_ready) nextState = IDLE;
      end
      default: nextState = IDLE;
    endcase

    // Abort overrides every transition and suppresses all side effects of
    // the aborted cycle. in_ready drops too so stage 1 never sees a
    // handshake that the controller is about to discard.
    if (flush) begin
      nextState  = IDLE;
      inReadyC   = 1'b0;
      memRdC     = 1'b0;
      writeOpC   = 1'b0;
      writeAC    = 1'b0;
      writeBC    = 1'b0;
      writeDestC = 1'b0;
      valAC      = 1'b0;
    end
  end

  // Reset is synchronous, so the state register may still hold a mid-flight
  // state during the reset cycle; gate outputs so nothing escapes then.
  assign in_ready  = inReadyC   && !reset;
  assign mem_rd    = memRdC     && !reset;
  assign mem_addr  = memAddrC;
  assign writeOp   = writeOpC   && !reset;
  assign writeA    = writeAC    && !reset;
  assign writeB    = writeBC    && !reset;
  assign writeDest = writeDestC && !reset;
  assign valA      = valAC      && !reset;
  assign out_valid = outValidC  && !reset;

endmodule

// File: tb/tb_stage_2_control.sv
// Purpose: directed bench for stage_2_control with memory and stage 2 register models.
// Latency: n/a (testbench).
// Backpressure: exercises out_ready stalls in DONE.
module tb_stage_2_control;

`ifdef STAGE2_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_pc;
  logic        in_ready;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] memOut;
  logic        fwd_valid;
  logic [15:0] fwd_addr;
  logic        writeOp, writeA, writeB, writeDest, valA, out_valid;
  logic        out_ready;

  logic [15:0] mem [0:65535];
  logic [15:0] valA1;
  logic [7:0]  s2Op;
  logic [15:0] s2A, s2B, s2Dest;
  logic [15:0] rdLog [$];

  int nVec = 0;
  int nMis = 0;
  int cyc  = 0;
  int tAcc = 0;

  stage_2_control dut (
    .CLK(CLK), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_pc(in_pc), .in_ready(in_ready),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .MemOut(memOut),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr),
    .writeOp(writeOp), .writeA(writeA), .writeB(writeB), .writeDest(writeDest),
    .valA(valA), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 CLK = ~CLK;

  // Memory returns data the cycle after the read; stage 2 registers capture
  // on their write enables.
  always @(posedge CLK) begin
    if (mem_rd) begin
      memOut <= mem[mem_addr];
      rdLog.push_back(mem_addr);
    end
    if (writeOp)   s2Op   <= memOut[15:8];
    if (writeA)    s2A    <= valA ? valA1 : memOut;
    if (writeB)    s2B    <= memOut;
    if (writeDest) s2Dest <= memOut;
  end

  typedef struct {
    logic        inValid;
    logic [15:0] inPc;
    logic        outReady;
    logic [23:0] exp;  // {in_ready, mem_rd, mem_addr, writeOp, writeA, writeB, writeDest, valA, out_valid}
  } vec_t;

  function automatic logic [23:0] ev(input logic rdy, input logic rd, input logic [15:0] a,
                                      input logic [5:0] wr);
    return {rdy, rd, a, wr};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    #1;
    cyc++;
  endtask

  // Presents pc in an IDLE cycle; returns one cycle later with in_valid low.
  task automatic startTxn(input logic [15:0] pc);
    tick();
    in_valid = 1'b1;
    in_pc    = pc;
    #1;
    chk("accept_rdy", in_ready, 1);
    tAcc = cyc;
    tick();
    in_valid = 1'b0;
    #1;
  endtask

  task automatic waitDone(output int lat);
    lat = -1;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        lat = cyc - tAcc;
        break;
      end
      tick();
    end
  endtask

  vec_t vecs [12];
  int   lat;
  int   hits;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
    mem[16'h0100] = 16'h2A00; mem[16'h0101] = 16'h0200;
    mem[16'h0102] = 16'h0300; mem[16'h0103] = 16'h0400;
    mem[16'h0200] = 16'h1111; mem[16'h0300] = 16'h2222;
    mem[16'hFFFE] = 16'h3B00; mem[16'hFFFF] = 16'h0200;
    mem[16'h0000] = 16'h0200; mem[16'h0001] = 16'h0500;

    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = 16'h0000;
    fwd_valid = 1'b0; fwd_addr = 16'h0000; out_ready = 1'b0; valA1 = 16'h0000;

    // Basic transaction, one record per cycle; cycle 1 is the accepting cycle T.
    vecs[0]  = '{1'b0, 16'h0000, 1'b0, ev(1, 0, 16'h0000, 6'b000000)};
    vecs[1]  = '{1'b1, 16'h0100, 1'b0, ev(1, 0, 16'h0000, 6'b000000)};
    vecs[2]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0100, 6'b000000)};
    vecs[3]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0101, 6'b100000)};
    vecs[4]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0102, 6'b000000)};
    vecs[5]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0103, 6'b000000)};
    vecs[6]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0200, 6'b000100)};
    vecs[7]  = '{1'b0, 16'h0000, 1'b0, ev(0, 1, 16'h0300, 6'b010000)};
    vecs[8]  = '{1'b0, 16'h0000, 1'b0, ev(0, 0, 16'h0000, 6'b001000)};
    vecs[9]  = '{1'b0, 16'h0000, 1'b0, ev(0, 0, 16'h0000, 6'b000001)};
    vecs[10] = '{1'b0, 16'h0000, 1'b1, ev(0, 0, 16'h0000, 6'b000001)};
    vecs[11] = '{1'b0, 16'h0000, 1'b0, ev(1, 0, 16'h0000, 6'b000000)};

    // Outputs held quiet while reset is asserted.
    tick();
    tick();
    chk("reset_outs", {mem_rd, writeOp, writeA, writeB, writeDest, valA, out_valid}, 0);

    for (int i = 0; i < 12; i++) begin
      tick();
      reset     = 1'b0;
      in_valid  = vecs[i].inValid;
      in_pc     = vecs[i].inPc;
      out_ready = vecs[i].outReady;
      #1;
      chk($sformatf("vec%0d", i),
          {in_ready, mem_rd, mem_addr, writeOp, writeA, writeB, writeDest, valA, out_valid},
          vecs[i].exp);
    end
    chk("basic_op",   s2Op,   8'h2A);
    chk("basic_A",    s2A,    16'h1111);
    chk("basic_B",    s2B,    16'h2222);
    chk("basic_dest", s2Dest, 16'h0400);

    // Forward: A pointer matches a pending result.
    fwd_valid = 1'b1; fwd_addr = 16'h0200; valA1 = 16'hBEEF;
    rdLog.delete();
    startTxn(16'h0100);
    repeat (4) tick();  // now at T+5 (RDA)
    chk("fwd_rda", {writeDest, writeA, valA, mem_addr},
        FWD ? {3'b111, 16'h0300} : {3'b100, 16'h0200});
    waitDone(lat);
    chk("fwd_latency", lat, FWD ? 7 : 8);
    hits = 0;
    foreach (rdLog[i]) if (rdLog[i] == 16'h0200) hits++;
    chk("fwd_a_reads", hits, FWD ? 0 : 1);
    chk("fwd_A",    s2A,    FWD ? 16'hBEEF : 16'h1111);
    chk("fwd_B",    s2B,    16'h2222);
    chk("fwd_dest", s2Dest, 16'h0400);
    fwd_valid = 1'b0;

    // Backpressure in DONE; a new in_valid must not be taken until IDLE.
    in_valid = 1'b1; in_pc = 16'h0100;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("bp_hold%0d", i), {out_valid, in_ready, mem_rd}, 3'b100);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("bp_release", {out_valid, in_ready}, 2'b10);
    tick();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    #1;
    chk("bp_idle", {out_valid, in_ready, mem_rd}, 3'b010);
    tick();
    chk("bp_noaccept", {in_ready, mem_rd}, 2'b10);

    // Address wrap, with A and B pointers equal (both read from memory).
    rdLog.delete();
    startTxn(16'hFFFE);
    waitDone(lat);
    chk("wrap_latency", lat, 8);
    chk("wrap_nreads", rdLog.size(), 6);
    if (rdLog.size() == 6) begin
      chk("wrap_rd0", rdLog[0], 16'hFFFE);
      chk("wrap_rd1", rdLog[1], 16'hFFFF);
      chk("wrap_rd2", rdLog[2], 16'h0000);
      chk("wrap_rd3", rdLog[3], 16'h0001);
      chk("same_rdA", rdLog[4], 16'h0200);
      chk("same_rdB", rdLog[5], 16'h0200);
    end
    chk("wrap_op", s2Op, 8'h3B);
    chk("wrap_AB", {s2A, s2B}, {16'h1111, 16'h1111});
    chk("wrap_dest", s2Dest, 16'h0500);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Flush in RDB: no A write, IDLE next cycle.
    startTxn(16'h0100);
    repeat (5) tick();  // now at T+6 (RDB)
    flush = 1'b1;
    #1;
    chk("flush_wr", {writeOp, writeA, writeB, writeDest, valA}, 0);
    tick();
    flush = 1'b0;
    #1;
    chk("flush_idle", {in_ready, mem_rd, out_valid}, 3'b100);

    // Reset pulse in RD2.
    startTxn(16'h0100);
    tick();  // now at T+2 (RD1)
    tick();  // now at T+3 (RD2)
    chk("rst_rd2", {mem_rd, mem_addr}, {1'b1, 16'h0102});
    reset = 1'b1;
    #1;
    chk("rst_outs", {mem_rd, writeOp, writeA, writeB, writeDest, valA, out_valid}, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("rst_idle", {in_ready, mem_rd, out_valid}, 3'b100);

    // Fresh transaction after the abort completes normally.
    startTxn(16'h0100);
    waitDone(lat);
    chk("post_rst_latency", lat, 8);
    chk("post_rst_dest", s2Dest, 16'h0400);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

// File: doc/stage_2_control.md
STAGE_2_CONTROL -- requirements
Module: stage_2_control

Interface
REQ-001 SHALL have no parameters; all widths fixed (16-bit data/address, 8-bit opcode field in stage 2).
REQ-002 SHALL have one clock; reset is synchronous and active-high.
REQ-003 CLK  in  1  rising-edge clock.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 flush  in  1  synchronous abort; return to IDLE.
REQ-006 in_valid  in  1  stage 1 offers an instruction pointer.
REQ-007 in_pc  in  16  address of the 4-word instruction: op, A pointer, B pointer, Dest address.
REQ-008 in_ready  out  1  controller can accept in_pc.
REQ-009 mem_rd  out  1  memory read strobe.
REQ-010 mem_addr  out  16  memory read address.
REQ-011 MemOut  in  16  memory read data, valid the cycle after mem_rd.
REQ-012 fwd_valid  in  1  a later stage holds a pending result.
REQ-013 fwd_addr  in  16  destination address of that pending result.
REQ-014 writeOp, writeA, writeB, writeDest  out  1 each  stage 2 register write enables.
REQ-015 valA  out  1  A-source select: 0 = MemOut, 1 = forwarded valA1.
REQ-016 out_valid  out  1  stage 2 registers hold a complete instruction.
REQ-017 out_ready  in  1  downstream consumes the instruction.

Function
REQ-018 SHALL implement the FSM IDLE, RD0, RD1, RD2, RD3, RDA, RDB, WB, DONE.
REQ-019 SHALL issue at most one read per cycle, with mem_rd and mem_addr decoded from state only, except the RDA forward decision.
REQ-020 IDLE: in_ready=1; when in_valid=1, latch pc_r<=in_pc and go to RD0; in_ready=0 in all other states.
REQ-021 RD0: read pc_r -> RD1.
REQ-022 RD1: writeOp=1; read pc_r+1 -> RD2.
REQ-023 RD2: aaddr_r<=MemOut; read pc_r+2 -> RD3.
REQ-024 RD3: baddr_r<=MemOut; read pc_r+3 -> RDA.
REQ-025 RDA on forward hit (fwd_valid=1 and fwd_addr==aaddr_r): writeDest=1, writeA=1, valA=1, read baddr_r -> WB.
REQ-026 RDA on no hit: writeDest=1, read aaddr_r -> RDB.
REQ-027 RDB: writeA=1, valA=0; read baddr_r -> WB.
REQ-028 WB: writeB=1 -> DONE.
REQ-029 DONE: out_valid=1; hold until out_ready=1, then go to IDLE; a new in_valid is not accepted in that same cycle.
REQ-030 Latency from the accepting IDLE cycle T: out_valid at T+8 without a forward hit, T+7 with one.
REQ-031 pc_r+k SHALL wrap modulo 2^16 (0xFFFE+3 = 0x0001).
REQ-032 valA SHALL be 0 in every cycle where writeA=0.
REQ-033 Write enables SHALL be mutually exclusive, except writeDest with writeA in RDA.
REQ-034 flush in any state SHALL go to IDLE next cycle with all write enables 0 in that cycle; flush has priority over all transitions, including DONE with out_ready.
REQ-035 If aaddr_r==baddr_r, both operands SHALL be read from memory; no address coalescing.

Reset
REQ-036 reset=1 SHALL force state IDLE and pc_r, aaddr_r, baddr_r to 0x0000.
REQ-037 During and after reset: mem_rd, write enables, valA, out_valid = 0; in_ready=1 from the first cycle after reset.
REQ-038 reset SHALL take priority over flush and abort any sequence mid-operation.

Configuration
REQ-039 Macro STAGE2_FWD_EN defined: forward-hit path of REQ-025 active.
REQ-040 Macro STAGE2_FWD_EN undefined: RDA always takes the no-hit path, valA tied 0, fwd_valid/fwd_addr ignored; latency always T+8.

Verification
REQ-041 Basic: in_pc=0x0100, mem[0x100..0x103]={0x2A00,0x0200,0x0300,0x0400}, mem[0x200]=0x1111, mem[0x300]=0x2222 -> writeOp T+2, writeDest T+5, writeA/valA=0 T+6, writeB T+7, out_valid T+8; stage 2 holds Op=0x2A, A=0x1111, B=0x2222, Dest=0x0400.
REQ-042 Forward: same setup, fwd_valid=1, fwd_addr=0x0200, valA1=0xBEEF at T+5 -> writeA=valA=1 at T+5, no read of 0x0200, A=0xBEEF, out_valid T+7; with STAGE2_FWD_EN undefined -> A=0x1111, out_valid T+8.
REQ-043 Wrap: in_pc=0xFFFE -> reads 0xFFFE, 0xFFFF, 0x0000, 0x0001 in RD0..RD3.
REQ-044 Backpressure: out_ready=0 for 5 cycles in DONE -> out_valid held, in_ready=0, no mem_rd; out_ready=1 -> IDLE next cycle.
REQ-045 Abort: flush at RDB -> IDLE next cycle, writeA=0; reset pulse at RD2 -> all outputs 0, in_ready=1 after release.
